fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch controller for the single-issue RV32I core. Owns the program counter and drives the combinational instruction memory's address input. Buffers fetched {pc, instr} pairs in a small prefetch FIFO that feeds decode through a valid/ready handshake. Accepts branch/jump redirects from execute; a redirect flushes all in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
FIFO_DEPTH, 2, number of prefetch entries; power of two, at least 2.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  asynchronous reset, active-low.
imem_addr  output  32  byte address to instruction memory (memory indexes by addr[31:2]).
imem_rdata  input  32  instruction word from memory, valid in the same cycle as imem_addr.
imem_valid  input  1  memory data usable this cycle; tie to 1 for zero-wait memory.
redirect_valid  input  1  single-cycle pulse from execute: taken branch, jal or jalr.
redirect_pc  input  32  redirect target, sampled when redirect_valid=1.
if_valid  output  1  FIFO head entry valid.
if_ready  input  1  decode accepts the head entry this cycle.
if_instr  output  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
if_pc  output  32  head PC; 0 when if_valid=0.
if_misalign  output  1  misaligned-redirect flag (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc <= RESET_PC; FIFO emptied (count=0, read and write pointers = 0).
  - if_valid=0, if_instr=NOP, if_pc=0, if_misalign=0.
  - Reset asserted mid-operation discards all entries immediately.
- imem_addr = pc, combinational from the pc register.
- pop = if_valid & if_ready.
- push = imem_valid & (count<FIFO_DEPTH | pop) & ~redirect_valid & ~halted.
  - halted is 0 unless the optional feature sets it.
- On push: write {pc, imem_rdata} at the write pointer; pc <= pc+4.
  - pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 by modulo-2^32 add; no flag.
- Latency: fetch at cycle N appears on if_* at cycle N+1.
  - Steady-state throughput is one instruction per cycle while decode keeps if_ready=1.
- Full FIFO with pop in the same cycle: push is allowed and count is unchanged.
- Full FIFO without pop: no push, pc holds.
- Empty FIFO: if_valid=0 and pop is ignored.
  - No bypass path exists: an empty FIFO always gives one bubble.
- Redirect (highest priority, same cycle as any push or pop):
  - FIFO flushed (count <= 0, pointers reset); any concurrent pop completes normally.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No fetch in the redirect cycle. First fetch from the target at N+1, visible on if_* at N+2.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- if_* outputs are driven from the FIFO head (registered storage); no combinational path from imem_rdata to if_*.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 flushes the FIFO, loads pc with the aligned target, and sets halted=1 and if_misalign=1.
  - While halted: no pushes, if_valid=0.
  - The next redirect with aligned redirect_pc clears both flags and resumes normal fetch.
  - Reset clears both flags.
- Undefined:
  - redirect_pc[1:0] is silently ignored.
  - if_misalign is tied to 0 and halted is constant 0.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t: packed struct {pc[31:0], instr[31:0]}.
  - localparam NOP_INSTR = 32'h0000_0013.
  - localparam ILEN_BYTES = 4.
- One sub-module, fetch_fifo: parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
- fetch_unit keeps the pc register, push/redirect priority logic and the misalign flag logic.

Test Plan:
- Reset then release, imem_rdata=mem[addr>>2], if_ready=1: if_pc sequence 0,4,8,12 on consecutive cycles starting 1 cycle after release; if_valid stays high.
- if_ready=0 for 5 cycles: count saturates at 2, imem_addr holds at 8, if_pc holds 0. Then if_ready=1: entries 0,4,8 delivered in order with no loss or duplication.
- redirect_valid pulse with redirect_pc=32'h40 while the FIFO holds 2 entries: next cycle if_valid=0 and imem_addr=32'h40; if_pc=32'h40 appears 2 cycles after the redirect.
- imem_valid toggling 1,0,1,0 with if_ready=1: if_valid follows the pattern one cycle later; PCs 0,4 delivered with no PC skip.
- Force pc near the top via redirect_pc=32'hFFFF_FFF8: consecutive if_pc values FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_MISALIGN_TRAP_EN defined, redirect_pc=32'h0000_0022: if_misalign=1, if_valid stays 0. Then redirect to 32'h30: if_misalign=0, if_pc=32'h30 delivered. Asserting rst_n=0 mid-burst gives if_valid=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] ILEN_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr}: one-cycle write-to-head latency, no bypass;
// refuses pushes when full unless the head is popped in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO may still accept a write because the popped slot is the one written.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// PC owner and fetch controller; fetch at cycle N is visible on if_* at N+1, redirect
// flushes and refetches. Stalls pc when the FIFO is full. Misalign trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_misalign
);

  logic [31:0]  pc;
  logic         halted;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  assign imem_addr = pc;
  assign if_valid  = ~empty;
  assign pop       = if_valid & if_ready;
  assign push      = imem_valid & (~full | pop) & ~redirect_valid & ~halted;
  assign if_instr  = if_valid ? head.instr : NOP_INSTR;
  assign if_pc     = if_valid ? head.pc    : 32'h0;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc;
    wr_entry.instr = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
    else if (push)           pc <= pc + ILEN_BYTES;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Any redirect re-evaluates the trap, so an aligned redirect is the only way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted <= 1'b0;
    else if (redirect_valid) halted <= |redirect_pc[1:0];
  end

  assign if_misalign = halted;
`else
  logic unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];
  assign halted          = 1'b0;
  assign if_misalign     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit against a combinational memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_misalign    (if_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 with reset released; the next edge is the first fetch.
  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    imem_valid     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = rdy;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    rst_n = 1'b0;
    #2;
    checks += 5;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
    if (if_instr !== NOP_INSTR) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_instr, NOP_INSTR); end
    if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    if (if_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0b exp=0", if_misalign); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] epc;
      epc = 32'(4 * k);
      tick();
      checks += 3;
      if (if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%0b exp=1", k, if_valid); end
      if (if_pc !== epc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, if_pc, epc); end
      if (if_instr !== mem_word(epc)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, if_instr, mem_word(epc)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks += 2;
      if (if_pc !== 32'h0) begin failures++; $display("FAIL bp_hold_pc[%0d] got=%h exp=0", k, if_pc); end
      if (if_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%0b exp=1", k, if_valid); end
    end
    checks++;
    if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] epc;
      epc = 32'(4 * k);
      checks++;
      if (if_pc !== epc) begin failures++; $display("FAIL bp_drain[%0d] got=%h exp=%h", k, if_pc, epc); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    checks += 2;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0b exp=0", if_valid); end
    if (imem_addr !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
    tick();
    checks += 3;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%0b exp=1", if_valid); end
    if (if_pc !== 32'h40) begin failures++; $display("FAIL redir_pc got=%h exp=40", if_pc); end
    if (if_instr !== mem_word(32'h40)) begin failures++; $display("FAIL redir_instr got=%h exp=%h", if_instr, mem_word(32'h40)); end
    tick();
    checks++;
    if (if_pc !== 32'h44) begin failures++; $display("FAIL redir_next got=%h exp=44", if_pc); end
  endtask

  task automatic test_imem_valid();
    logic        pat   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] pcs   [4] = '{32'h0, 32'h0, 32'h4, 32'h0};
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      imem_valid = pat[k];
      tick();
      checks += 2;
      if (if_valid !== pat[k]) begin failures++; $display("FAIL ivld_valid[%0d] got=%0b exp=%0b", k, if_valid, pat[k]); end
      if (if_pc !== pcs[k]) begin failures++; $display("FAIL ivld_pc[%0d] got=%h exp=%h", k, if_pc, pcs[k]); end
    end
    imem_valid = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 2;
      if (if_pc !== exp_pc[k]) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, if_pc, exp_pc[k]); end
      if (if_instr !== mem_word(exp_pc[k])) begin failures++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", k, if_instr, mem_word(exp_pc[k])); end
    end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (if_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag[%0d] got=%0b exp=1", k, if_misalign); end
      if (if_valid !== 1'b0) begin failures++; $display("FAIL mis_halt[%0d] got=%0b exp=0", k, if_valid); end
      if (imem_addr !== 32'h20) begin failures++; $display("FAIL mis_addr[%0d] got=%h exp=20", k, imem_addr); end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (if_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0b exp=0", if_misalign); end
    tick();
    checks += 2;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL mis_resume_valid got=%0b exp=1", if_valid); end
    if (if_pc !== 32'h30) begin failures++; $display("FAIL mis_resume_pc got=%h exp=30", if_pc); end
`else
    checks += 2;
    if (if_misalign !== 1'b0) begin failures++; $display("FAIL mis_off_flag got=%0b exp=0", if_misalign); end
    if (imem_addr !== 32'h20) begin failures++; $display("FAIL mis_off_addr got=%h exp=20", imem_addr); end
    tick();
    checks += 3;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL mis_off_valid got=%0b exp=1", if_valid); end
    if (if_pc !== 32'h20) begin failures++; $display("FAIL mis_off_pc got=%h exp=20", if_pc); end
    if (if_misalign !== 1'b0) begin failures++; $display("FAIL mis_off_flag2 got=%0b exp=0", if_misalign); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick();
    tick();
    checks++;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", if_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", if_valid); end
    if (if_pc !== 32'h0) begin failures++; $display("FAIL areset_pc got=%h exp=0", if_pc); end
    if (if_instr !== NOP_INSTR) begin failures++; $display("FAIL areset_instr got=%h exp=%h", if_instr, NOP_INSTR); end
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_valid     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_imem_valid();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
